// File: rtl/ex_flags_stage_pkg.sv
// Shared types and constants for the EX/MEM flag stage and its condition evaluator.
package ex_pkg;

  localparam int DATA_W = 64;
  localparam int REG_AW = 5;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_HS = 4'h2,
    COND_LO = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  function automatic nzcv_t pack_nzcv(input logic n, input logic z,
                                      input logic c, input logic v);
    nzcv_t f;
    f.n = n;
    f.z = z;
    f.c = c;
    f.v = v;
    return f;
  endfunction

endpackage

// File: rtl/ex_flags_stage_cond_eval.sv
// Pure combinational ARM condition-code evaluator; reused by the early-branch unit.
module cond_eval
  import ex_pkg::*;
(
  input  nzcv_t flags,
  input  cond_e cond,
  output logic  taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = flags.z;
      COND_NE: taken = !flags.z;
      COND_HS: taken = flags.c;
      COND_LO: taken = !flags.c;
      COND_MI: taken = flags.n;
      COND_PL: taken = !flags.n;
      COND_VS: taken = flags.v;
      COND_VC: taken = !flags.v;
      COND_HI: taken = flags.c && !flags.z;
      COND_LS: taken = !flags.c || flags.z;
      COND_GE: taken = (flags.n == flags.v);
      COND_LT: taken = (flags.n != flags.v);
      COND_GT: taken = !flags.z && (flags.n == flags.v);
      COND_LE: taken = flags.z || (flags.n != flags.v);
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_flags_stage.sv
// EX/MEM boundary register with architectural NZCV ownership and branch resolution.
// Define FLAG_BYPASS_EN to forward live adder flags for every flag-setting instruction.
module ex_flags_stage
  import ex_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int REG_AW_P = REG_AW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ex_valid,
  input  logic [DATA_W_P-1:0] ex_result,
  input  logic                ex_zero,
  input  logic                ex_negative,
  input  logic                ex_carry,
  input  logic                ex_overflow,
  input  logic                ex_set_flags,
  input  logic                ex_reg_write,
  input  logic [REG_AW_P-1:0] ex_rd,
  input  logic                ex_is_bcond,
  input  logic [3:0]          ex_cond,
  input  logic                ex_is_cbz,
  input  logic                ex_cbz_neg,
  input  logic                stall,
  input  logic                flush,
  output logic                mem_valid,
  output logic [DATA_W_P-1:0] mem_result,
  output logic [REG_AW_P-1:0] mem_rd,
  output logic                mem_reg_write,
  output logic                mem_branch_taken,
  output logic [3:0]          flags_q
);

  nzcv_t flags_r;
  nzcv_t ex_flags;
  nzcv_t src_flags;
  logic  fwd_sel;
  logic  cond_taken;
  logic  cbz_taken;
  logic  taken_c;
  logic  advance;

  assign ex_flags = pack_nzcv(ex_negative, ex_zero, ex_carry, ex_overflow);
  assign advance  = ex_valid && !stall && !flush;

`ifdef FLAG_BYPASS_EN
  logic flag_write_pending;

  // Marks that the instruction now entering MEM wrote NZCV on this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_write_pending <= 1'b0;
    end else if (flush) begin
      flag_write_pending <= 1'b0;
    end else if (!stall) begin
      flag_write_pending <= ex_valid && ex_set_flags;
    end
  end

  assign fwd_sel = ex_set_flags;
`else
  assign fwd_sel = ex_set_flags && ex_is_bcond;
`endif

  assign src_flags = fwd_sel ? ex_flags : flags_r;

  cond_eval u_cond_eval (
    .flags (src_flags),
    .cond  (cond_e'(ex_cond)),
    .taken (cond_taken)
  );

  // CBZ/CBNZ looks at the operand through the adder, never at flags_q.
  assign cbz_taken = ex_zero ^ ex_cbz_neg;

  always_comb begin
    taken_c = 1'b0;
    if (ex_is_bcond) begin
      taken_c = cond_taken;
    end else if (ex_is_cbz) begin
      taken_c = cbz_taken;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_valid        <= 1'b0;
      mem_result       <= '0;
      mem_rd           <= '0;
      mem_reg_write    <= 1'b0;
      mem_branch_taken <= 1'b0;
      flags_r          <= '0;
    end else if (flush) begin
      mem_valid        <= 1'b0;
      mem_reg_write    <= 1'b0;
      mem_branch_taken <= 1'b0;
    end else if (!stall) begin
      if (advance) begin
        mem_valid        <= 1'b1;
        mem_result       <= ex_result;
        mem_rd           <= ex_rd;
        mem_reg_write    <= ex_reg_write;
        mem_branch_taken <= taken_c;
        if (ex_set_flags) begin
          flags_r <= ex_flags;
        end
      end else begin
        mem_valid        <= 1'b0;
        mem_reg_write    <= 1'b0;
        mem_branch_taken <= 1'b0;
      end
    end
  end

  assign flags_q = flags_r;

endmodule

// File: tb/tb_ex_flags_stage.sv
// Directed self-checking bench for ex_flags_stage using immediate assertions.
module tb_ex_flags_stage;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic [63:0] ex_result;
  logic        ex_zero;
  logic        ex_negative;
  logic        ex_carry;
  logic        ex_overflow;
  logic        ex_set_flags;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;
  logic        ex_is_bcond;
  logic [3:0]  ex_cond;
  logic        ex_is_cbz;
  logic        ex_cbz_neg;
  logic        stall;
  logic        flush;
  logic        mem_valid;
  logic [63:0] mem_result;
  logic [4:0]  mem_rd;
  logic        mem_reg_write;
  logic        mem_branch_taken;
  logic [3:0]  flags_q;

  int compared;
  int mismatched;

  ex_flags_stage dut (
    .clk              (clk),
    .reset            (reset),
    .ex_valid         (ex_valid),
    .ex_result        (ex_result),
    .ex_zero          (ex_zero),
    .ex_negative      (ex_negative),
    .ex_carry         (ex_carry),
    .ex_overflow      (ex_overflow),
    .ex_set_flags     (ex_set_flags),
    .ex_reg_write     (ex_reg_write),
    .ex_rd            (ex_rd),
    .ex_is_bcond      (ex_is_bcond),
    .ex_cond          (ex_cond),
    .ex_is_cbz        (ex_is_cbz),
    .ex_cbz_neg       (ex_cbz_neg),
    .stall            (stall),
    .flush            (flush),
    .mem_valid        (mem_valid),
    .mem_result       (mem_result),
    .mem_rd           (mem_rd),
    .mem_reg_write    (mem_reg_write),
    .mem_branch_taken (mem_branch_taken),
    .flags_q          (flags_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drives one EX-stage instruction; flag order matches {N,Z,C,V}.
  task automatic applyStimulus(input logic v, input logic [63:0] res,
                               input logic [3:0] nzcv, input logic setf,
                               input logic rw, input logic [4:0] rd,
                               input logic bc, input logic [3:0] cond,
                               input logic cbz, input logic cbzneg);
    ex_valid     = v;
    ex_result    = res;
    ex_negative  = nzcv[3];
    ex_zero      = nzcv[2];
    ex_carry     = nzcv[1];
    ex_overflow  = nzcv[0];
    ex_set_flags = setf;
    ex_reg_write = rw;
    ex_rd        = rd;
    ex_is_bcond  = bc;
    ex_cond      = cond;
    ex_is_cbz    = cbz;
    ex_cbz_neg   = cbzneg;
  endtask

  task automatic stepEdge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".valid"}, {63'd0, mem_valid}, 64'd0);
    checkOutput({tag, ".result"}, mem_result, 64'd0);
    checkOutput({tag, ".rd"}, {59'd0, mem_rd}, 64'd0);
    checkOutput({tag, ".rw"}, {63'd0, mem_reg_write}, 64'd0);
    checkOutput({tag, ".taken"}, {63'd0, mem_branch_taken}, 64'd0);
    checkOutput({tag, ".flags"}, {60'd0, flags_q}, 64'd0);
  endtask

  initial begin
    logic [15:0] exp_vec;
    compared   = 0;
    mismatched = 0;
    stall      = 1'b0;
    flush      = 1'b0;

    // Reset with random EX activity, checked before the first edge
    reset = 1'b1;
    applyStimulus(1'b1, {$urandom, $urandom}, 4'($urandom), 1'b1, 1'b1,
                  5'($urandom), 1'b1, 4'($urandom), 1'b0, 1'b0);
    #1;
    checkAllZero("reset_pre_edge");
    stepEdge();
    checkAllZero("reset_held");
    reset = 1'b0;

    // SUBS 5-5: result 0, Z=1 C=1
    applyStimulus(1'b1, 64'd0, 4'b0110, 1'b1, 1'b1, 5'd3, 1'b0, 4'h0, 1'b0, 1'b0);
    stepEdge();
    checkOutput("subs55.valid", {63'd0, mem_valid}, 64'd1);
    checkOutput("subs55.result", mem_result, 64'd0);
    checkOutput("subs55.rd", {59'd0, mem_rd}, 64'd3);
    checkOutput("subs55.rw", {63'd0, mem_reg_write}, 64'd1);
    checkOutput("subs55.flags", {60'd0, flags_q}, 64'h6);
    checkOutput("subs55.taken", {63'd0, mem_branch_taken}, 64'd0);

    // B.EQ behind it reads registered Z=1
    applyStimulus(1'b1, 64'h1234, 4'b0000, 1'b0, 1'b0, 5'd0, 1'b1, 4'h0, 1'b0, 1'b0);
    stepEdge();
    checkOutput("beq.taken", {63'd0, mem_branch_taken}, 64'd1);
    checkOutput("beq.flags", {60'd0, flags_q}, 64'h6);
    checkOutput("beq.rw", {63'd0, mem_reg_write}, 64'd0);

    // Sweep all 16 codes against flags 0110
    exp_vec = 16'hE6A5;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 64'd0, 4'b0000, 1'b0, 1'b0, 5'd0, 1'b1, 4'(i), 1'b0, 1'b0);
      stepEdge();
      checkOutput($sformatf("cond0110_%0d", i), {63'd0, mem_branch_taken},
                  {63'd0, exp_vec[i]});
    end

    // SUBS 1-2: N=1 C=0
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1'b1, 1'b1, 5'd4,
                  1'b0, 4'h0, 1'b0, 1'b0);
    stepEdge();
    checkOutput("subs12.flags", {60'd0, flags_q}, 64'h8);
    checkOutput("subs12.result", mem_result, 64'hFFFF_FFFF_FFFF_FFFF);

    applyStimulus(1'b1, 64'd0, 4'b0000, 1'b0, 1'b0, 5'd0, 1'b1, 4'hB, 1'b0, 1'b0);
    stepEdge();
    checkOutput("blt.taken", {63'd0, mem_branch_taken}, 64'd1);
    applyStimulus(1'b1, 64'd0, 4'b0000, 1'b0, 1'b0, 5'd0, 1'b1, 4'hA, 1'b0, 1'b0);
    stepEdge();
    checkOutput("bge.taken", {63'd0, mem_branch_taken}, 64'd0);
    checkOutput("bge.flags", {60'd0, flags_q}, 64'h8);

    // Fused set-flags B.EQ uses forwarded Z=1 although flags_q has Z=0
    applyStimulus(1'b1, 64'h55, 4'b0100, 1'b1, 1'b0, 5'd7, 1'b1, 4'h0, 1'b0, 1'b0);
    stepEdge();
    checkOutput("fused.taken", {63'd0, mem_branch_taken}, 64'd1);
    checkOutput("fused.flags", {60'd0, flags_q}, 64'h4);

    // ADDS 0x7FFF..F + 1 held by a 3-cycle stall
    applyStimulus(1'b1, 64'h8000_0000_0000_0000, 4'b1001, 1'b1, 1'b1, 5'd9,
                  1'b0, 4'h0, 1'b0, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stepEdge();
      checkOutput($sformatf("stall%0d.result", i), mem_result, 64'h55);
      checkOutput($sformatf("stall%0d.rd", i), {59'd0, mem_rd}, 64'd7);
      checkOutput($sformatf("stall%0d.taken", i), {63'd0, mem_branch_taken}, 64'd1);
      checkOutput($sformatf("stall%0d.flags", i), {60'd0, flags_q}, 64'h4);
    end
    stall = 1'b0;
    stepEdge();
    checkOutput("unstall.result", mem_result, 64'h8000_0000_0000_0000);
    checkOutput("unstall.rd", {59'd0, mem_rd}, 64'd9);
    checkOutput("unstall.flags", {60'd0, flags_q}, 64'h9);
    checkOutput("unstall.taken", {63'd0, mem_branch_taken}, 64'd0);

    // flush overrides stall: ADDS 0+0 becomes a bubble, flags kept
    applyStimulus(1'b1, 64'd0, 4'b0100, 1'b1, 1'b1, 5'd2, 1'b1, 4'hE, 1'b0, 1'b0);
    stall = 1'b1;
    flush = 1'b1;
    stepEdge();
    checkOutput("flush.valid", {63'd0, mem_valid}, 64'd0);
    checkOutput("flush.rw", {63'd0, mem_reg_write}, 64'd0);
    checkOutput("flush.taken", {63'd0, mem_branch_taken}, 64'd0);
    checkOutput("flush.flags", {60'd0, flags_q}, 64'h9);
    stall = 1'b0;
    flush = 1'b0;

    // Sweep all 16 codes against flags 1001
    exp_vec = 16'hD65A;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 64'd0, 4'b0100, 1'b0, 1'b0, 5'd0, 1'b1, 4'(i), 1'b0, 1'b0);
      stepEdge();
      checkOutput($sformatf("cond1001_%0d", i), {63'd0, mem_branch_taken},
                  {63'd0, exp_vec[i]});
    end

    // CBZ / CBNZ on operand 0 use live Z, flags_q has Z=0
    applyStimulus(1'b1, 64'd0, 4'b0100, 1'b0, 1'b0, 5'd0, 1'b0, 4'h0, 1'b1, 1'b0);
    stepEdge();
    checkOutput("cbz.taken", {63'd0, mem_branch_taken}, 64'd1);
    checkOutput("cbz.flags", {60'd0, flags_q}, 64'h9);
    applyStimulus(1'b1, 64'd0, 4'b0100, 1'b0, 1'b0, 5'd0, 1'b0, 4'h0, 1'b1, 1'b1);
    stepEdge();
    checkOutput("cbnz.taken", {63'd0, mem_branch_taken}, 64'd0);
    checkOutput("cbnz.flags", {60'd0, flags_q}, 64'h9);

    // Bubble after a valid write: result/rd hold, controls clear
    applyStimulus(1'b1, 64'hABCD, 4'b0000, 1'b0, 1'b1, 5'd11, 1'b0, 4'h0, 1'b1, 1'b1);
    stepEdge();
    checkOutput("pre_bubble.rw", {63'd0, mem_reg_write}, 64'd1);
    checkOutput("pre_bubble.taken", {63'd0, mem_branch_taken}, 64'd1);
    applyStimulus(1'b0, 64'h1111, 4'b1111, 1'b1, 1'b1, 5'd12, 1'b0, 4'h0, 1'b1, 1'b1);
    stepEdge();
    checkOutput("bubble.valid", {63'd0, mem_valid}, 64'd0);
    checkOutput("bubble.rw", {63'd0, mem_reg_write}, 64'd0);
    checkOutput("bubble.taken", {63'd0, mem_branch_taken}, 64'd0);
    checkOutput("bubble.result", mem_result, 64'hABCD);
    checkOutput("bubble.rd", {59'd0, mem_rd}, 64'd11);
    checkOutput("bubble.flags", {60'd0, flags_q}, 64'h9);

    // Async reset while stalled, then resume on first edge
    applyStimulus(1'b1, 64'h77, 4'b0010, 1'b1, 1'b1, 5'd5, 1'b0, 4'h0, 1'b0, 1'b0);
    stepEdge();
    checkOutput("pre_rst.flags", {60'd0, flags_q}, 64'h2);
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("rst_mid_stall");
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    applyStimulus(1'b1, 64'h99, 4'b1000, 1'b1, 1'b1, 5'd6, 1'b0, 4'h0, 1'b0, 1'b0);
    stepEdge();
    checkOutput("post_rst.valid", {63'd0, mem_valid}, 64'd1);
    checkOutput("post_rst.result", mem_result, 64'h99);
    checkOutput("post_rst.flags", {60'd0, flags_q}, 64'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
